ex_operand_stage: RTL

ID/EX pipeline stage of the 64-bit RV64I core, sitting directly upstream of the ALU. It registers decoded instruction fields and operands each cycle and generates the 4-bit ALU opcode. It also resolves EX/MEM and MEM/WB forwarding, and drives the ALU's data1, data2 and ALUOp inputs. It detects load-use hazards and inserts bubbles, and honours pipeline-wide stall and flush.

---
 rtl/ex_operand_stage_if.sv | 74 +++++++
 rtl/ex_operand_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_operand_stage_if
//  Description : Bundle of signals between decode, the ID/EX operand stage,
//                the writeback sources and the ALU.
//                slave  - the operand stage view (consumes id_*, exm_*,
//                         mwb_*, stall, flush; produces alu_* and ex_*)
//                master - the surrounding pipeline view (opposite directions)
//  Revision    : 1.0  initial release
// ============================================================================
interface ex_operand_stage_if #(
   parameter int XLEN = 64,
   parameter int REGW = 5
);
   // decode side
   logic            id_valid;
   logic [6:0]      id_opcode;
   logic [2:0]      id_funct3;
   logic            id_funct7_5;
   logic [REGW-1:0] id_rs1;
   logic [REGW-1:0] id_rs2;
   logic [REGW-1:0] id_rd;
   logic [XLEN-1:0] id_rs1_data;
   logic [XLEN-1:0] id_rs2_data;
   logic [XLEN-1:0] id_imm;

   // pipeline control
   logic            stall;
   logic            flush;

   // writeback sources used for forwarding
   logic            exm_regwrite;
   logic [REGW-1:0] exm_rd;
   logic [XLEN-1:0] exm_result;
   logic            mwb_regwrite;
   logic [REGW-1:0] mwb_rd;
   logic [XLEN-1:0] mwb_result;

   // ALU / EX side
   logic [XLEN-1:0] alu_data1;
   logic [XLEN-1:0] alu_data2;
   logic [3:0]      alu_op;
   logic            ex_valid;
   logic            ex_regwrite;
   logic            ex_memread;
   logic            ex_memwrite;
   logic            ex_branch;
   logic [REGW-1:0] ex_rd;
   logic [XLEN-1:0] ex_store_data;
   logic            load_use_stall;

   modport slave (
      input  id_valid, id_opcode, id_funct3, id_funct7_5,
      input  id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
      input  stall, flush,
      input  exm_regwrite, exm_rd, exm_result,
      input  mwb_regwrite, mwb_rd, mwb_result,
      output alu_data1, alu_data2, alu_op,
      output ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch,
      output ex_rd, ex_store_data, load_use_stall
   );

   modport master (
      output id_valid, id_opcode, id_funct3, id_funct7_5,
      output id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
      output stall, flush,
      output exm_regwrite, exm_rd, exm_result,
      output mwb_regwrite, mwb_rd, mwb_result,
      input  alu_data1, alu_data2, alu_op,
      input  ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch,
      input  ex_rd, ex_store_data, load_use_stall
   );
endinterface
`default_nettype wire

// File: rtl/ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_operand_stage
//  Description : ID/EX pipeline stage of the RV64I core. Registers decoded
//                fields and operands, generates the 4-bit ALU opcode,
//                resolves EX/MEM and MEM/WB forwarding, detects load-use
//                hazards (inserting a bubble) and honours stall / flush.
//  Ports       : clk, rst_n (async, active low)
//                bus (ex_operand_stage_if.slave):
//                  id_*            decoded instruction from ID
//                  stall, flush    pipeline-wide hold / kill
//                  exm_*, mwb_*    forwarding sources
//                  alu_data1/2,
//                  alu_op          ALU operands and opcode
//                  ex_*            registered control, rd and store data
//                  load_use_stall  request upstream to hold IF/ID
//  Revision    : 1.0  initial release
// ============================================================================
module ex_operand_stage #(
   parameter int XLEN = 64,
   parameter int REGW = 5
) (
   input logic                clk,
   input logic                rst_n,
   ex_operand_stage_if.slave  bus
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b1000;

   // ------------------------------------------------------------------
   // Stage registers
   // ------------------------------------------------------------------
   logic            valid_q,    valid_d;
   logic            regwrite_q, regwrite_d;
   logic            memread_q,  memread_d;
   logic            memwrite_q, memwrite_d;
   logic            branch_q,   branch_d;
   logic            sel_rs2_q,  sel_rs2_d;   // operand 2 from rs2 (R, BRANCH)
   logic [REGW-1:0] rd_q,       rd_d;
   logic [REGW-1:0] rs1_q,      rs1_d;
   logic [REGW-1:0] rs2_q,      rs2_d;
   logic [XLEN-1:0] rs1_data_q, rs1_data_d;
   logic [XLEN-1:0] rs2_data_q, rs2_data_d;
   logic [XLEN-1:0] imm_q,      imm_d;
   logic [3:0]      alu_op_q,   alu_op_d;

   // ------------------------------------------------------------------
   // Decode of the instruction currently in ID
   // ------------------------------------------------------------------
   logic       is_r, is_i, is_load, is_store, is_branch, is_known;
   logic       id_uses_rs2;
   logic [3:0] id_alu_op;
   logic       load_use;

   always_comb begin
      is_r        = (bus.id_opcode == OP_R);
      is_i        = (bus.id_opcode == OP_I);
      is_load     = (bus.id_opcode == OP_LOAD);
      is_store    = (bus.id_opcode == OP_STORE);
      is_branch   = (bus.id_opcode == OP_BRANCH);
      is_known    = is_r | is_i | is_load | is_store | is_branch;
      id_uses_rs2 = is_r | is_store | is_branch;

      id_alu_op = ALU_ADD;
      if (is_r) begin
         id_alu_op = {bus.id_funct7_5, bus.id_funct3};
      end else if (is_i) begin
         // Bit 30 only selects srai; for addi it is just immediate bits.
         id_alu_op = {bus.id_funct7_5 & (bus.id_funct3 == 3'b101), bus.id_funct3};
      end else if (is_branch) begin
         id_alu_op = ALU_SUB;
      end
   end

   // Hazard against the load currently in EX. The rs1 compare is made
   // regardless of class so the check stays conservative.
   always_comb begin
      load_use = valid_q & memread_q & (rd_q != '0) & bus.id_valid &
                 ((rd_q == bus.id_rs1) | ((rd_q == bus.id_rs2) & id_uses_rs2));
   end

   // ------------------------------------------------------------------
   // Next-state selection: flush > stall > load-use bubble > capture
   // ------------------------------------------------------------------
   always_comb begin
      valid_d    = valid_q;
      regwrite_d = regwrite_q;
      memread_d  = memread_q;
      memwrite_d = memwrite_q;
      branch_d   = branch_q;
      sel_rs2_d  = sel_rs2_q;
      rd_d       = rd_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      imm_d      = imm_q;
      alu_op_d   = alu_op_q;

      if (bus.flush || (!bus.stall && load_use)) begin
         // Kill or bubble: only control is cleared, data simply holds.
         valid_d    = 1'b0;
         regwrite_d = 1'b0;
         memread_d  = 1'b0;
         memwrite_d = 1'b0;
         branch_d   = 1'b0;
      end else if (!bus.stall) begin
         valid_d    = bus.id_valid & is_known;
         regwrite_d = bus.id_valid & (is_r | is_i | is_load);
         memread_d  = bus.id_valid & is_load;
         memwrite_d = bus.id_valid & is_store;
         branch_d   = bus.id_valid & is_branch;
         sel_rs2_d  = is_r | is_branch;
         rd_d       = bus.id_rd;
         rs1_d      = bus.id_rs1;
         rs2_d      = bus.id_rs2;
         rs1_data_d = bus.id_rs1_data;
         rs2_data_d = bus.id_rs2_data;
         imm_d      = bus.id_imm;
         alu_op_d   = id_alu_op;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         regwrite_q <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
         branch_q   <= 1'b0;
         sel_rs2_q  <= 1'b0;
         rd_q       <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         alu_op_q   <= '0;
      end else begin
         valid_q    <= valid_d;
         regwrite_q <= regwrite_d;
         memread_q  <= memread_d;
         memwrite_q <= memwrite_d;
         branch_q   <= branch_d;
         sel_rs2_q  <= sel_rs2_d;
         rd_q       <= rd_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
         alu_op_q   <= alu_op_d;
      end
   end

   // ------------------------------------------------------------------
   // Forwarding: EX/MEM beats MEM/WB, x0 is never forwarded
   // ------------------------------------------------------------------
   logic [XLEN-1:0] fwd_rs1, fwd_rs2;

   always_comb begin
      fwd_rs1 = rs1_data_q;
      if (bus.exm_regwrite && (bus.exm_rd == rs1_q) && (rs1_q != '0)) begin
         fwd_rs1 = bus.exm_result;
      end else if (bus.mwb_regwrite && (bus.mwb_rd == rs1_q) && (rs1_q != '0)) begin
         fwd_rs1 = bus.mwb_result;
      end

      fwd_rs2 = rs2_data_q;
      if (bus.exm_regwrite && (bus.exm_rd == rs2_q) && (rs2_q != '0)) begin
         fwd_rs2 = bus.exm_result;
      end else if (bus.mwb_regwrite && (bus.mwb_rd == rs2_q) && (rs2_q != '0)) begin
         fwd_rs2 = bus.mwb_result;
      end
   end

   // ------------------------------------------------------------------
   // Outputs; control is gated by valid so an invalid slot never acts
   // ------------------------------------------------------------------
   assign bus.alu_data1      = fwd_rs1;
   assign bus.alu_data2      = sel_rs2_q ? fwd_rs2 : imm_q;
   assign bus.ex_store_data  = fwd_rs2;
   assign bus.alu_op         = alu_op_q;
   assign bus.ex_valid       = valid_q;
   assign bus.ex_regwrite    = valid_q & regwrite_q;
   assign bus.ex_memread     = valid_q & memread_q;
   assign bus.ex_memwrite    = valid_q & memwrite_q;
   assign bus.ex_branch      = valid_q & branch_q;
   assign bus.ex_rd          = rd_q;
   assign bus.load_use_stall = load_use;

endmodule
`default_nettype wire
